// File: rtl/uart_pkg.sv
// Shared UART definitions: 8N1 frame constants, RX/TX state encodings, and the
// default end-of-line byte.
package uart_pkg;

    localparam int         DATA_BITS   = 8;
    localparam int         BIT_IDX_W   = $clog2(DATA_BITS);
    localparam logic       LINE_IDLE   = 1'b1;
    localparam logic       START_BIT   = 1'b0;
    localparam logic       STOP_BIT    = 1'b1;
    localparam logic [7:0] EOL_DEFAULT = 8'h0D;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

endpackage

// File: rtl/uart_line_buffer_if.sv
// Byte FIFO access bus between the line-buffer core (master) and its FIFO (slave).
// Handshake: push is honoured only when full is low, and pop only when empty is
// low. pop_data shows the oldest entry, and the entry is consumed on a cycle
// with pop=1 and empty=0.
interface uart_line_buffer_if #(
    parameter int DEPTH = 32
) ();
    localparam int CW = $clog2(DEPTH + 1);

    logic          push;
    logic [7:0]    push_data;
    logic          pop;
    logic [7:0]    pop_data;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;

    modport master (output push, push_data, pop, input pop_data, full, empty, count);
    modport slave  (input push, push_data, pop, output pop_data, full, empty, count);
endinterface

// File: rtl/ulb_fifo.sv
// First-word-fall-through byte FIFO. Full and empty come from the registered
// count, so a pop in the same cycle never makes room for a push.
module ulb_fifo #(
    parameter int DEPTH = 32
) (
    input logic               clk_i,
    input logic               rst_ni,
    uart_line_buffer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          push_ok, pop_ok;

    assign bus.full     = (count_q == CW'(DEPTH));
    assign bus.empty    = (count_q == '0);
    assign bus.count    = count_q;
    assign bus.pop_data = mem_q[rd_ptr_q];

    assign push_ok = bus.push & ~bus.full;
    assign pop_ok  = bus.pop & ~bus.empty;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= bus.push_data;
    end

endmodule

// File: rtl/uart_line_buffer.sv
// UART line buffer: receives 8N1 bytes into a FIFO and sends them back either
// immediately (echo) or as a batch drain started by a rising edge on the send input.
module uart_line_buffer
    import uart_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 434,
    parameter int         DEPTH        = 32,
    parameter int         SHOW_BYTES   = 4,
    parameter logic [7:0] EOL_CHAR     = EOL_DEFAULT
) (
    input  logic                         i_Clk,
    input  logic                         i_Rst_n,
    input  logic                         i_UART_RXD,
    input  logic                         i_send_data_to_host_computer,
    input  logic                         i_echo_mode,
    output logic                         o_UART_TXD,
    output logic [8*SHOW_BYTES-1:0]      o_buffer,
    output logic [$clog2(DEPTH+1)-1:0]   o_count_data,
    output logic [7:0]                   o_last_tx,
    output logic                         o_eol,
    output logic                         o_overflow,
    output logic                         o_frame_err
);
    localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
    localparam int                CW        = $clog2(DEPTH + 1);
    localparam int                BW        = 8 * SHOW_BYTES;
    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_IDX_W-1:0] LAST_IDX = BIT_IDX_W'(DATA_BITS - 1);

    uart_line_buffer_if #(.DEPTH(DEPTH)) fifo_bus ();

    ulb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i  (i_Clk),
        .rst_ni (i_Rst_n),
        .bus    (fifo_bus.slave)
    );

    logic rxd_meta_q, rxd_sync_q, send_meta_q, send_sync_q, send_prev_q;

    rx_state_e            rx_state_q, rx_state_d;
    logic [CNT_W-1:0]     rx_cnt_q, rx_cnt_d;
    logic [BIT_IDX_W-1:0] rx_bit_q, rx_bit_d;
    logic [7:0]           rx_shift_q, rx_shift_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;

    tx_state_e            tx_state_q, tx_state_d;
    logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
    logic [BIT_IDX_W-1:0] tx_bit_q, tx_bit_d;
    logic [7:0]           tx_shift_q, tx_shift_d;
    logic [7:0]           tx_byte_q, tx_byte_d;
    logic [7:0]           last_tx_q, last_tx_d;
    logic                 tx_pop, tx_en;

    logic                 drain_q, drain_d, drain_done, send_rise;
    logic [BW-1:0]        buffer_q, buffer_d;
    logic                 eol_q, eol_d, overflow_q, overflow_d;
    logic                 push_ok, push_drop;

    // ---------------- RX frame decoder ----------------
    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (rxd_sync_q == START_BIT) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = '0;
                end
            end
            RX_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = (rxd_sync_q == LINE_IDLE) ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rxd_sync_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + BIT_IDX_W'(1);
                    if (rx_bit_q == LAST_IDX) rx_state_d = RX_STOP;
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_state_d = RX_IDLE;
                    rx_cnt_d   = '0;
                    if (rxd_sync_q == STOP_BIT) rx_valid_d  = 1'b1;
                    else                        frame_err_d = 1'b1;
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // rx_shift_q is stable in the cycle after the stop sample, so it feeds the FIFO directly.
    assign fifo_bus.push      = rx_valid_q;
    assign fifo_bus.push_data = rx_shift_q;
    assign fifo_bus.pop       = tx_pop;

    assign push_ok   = rx_valid_q & ~fifo_bus.full;
    assign push_drop = rx_valid_q & fifo_bus.full;

    // ---------------- drain control and status ----------------
    assign send_rise  = send_sync_q & ~send_prev_q;
    assign drain_done = drain_q & fifo_bus.empty & (tx_state_q == TX_IDLE);
    assign tx_en      = drain_q | i_echo_mode;

    always_comb begin
        drain_d    = drain_q ? ~drain_done : send_rise;
        buffer_d   = push_ok ? ((buffer_q << 8) | BW'(rx_shift_q)) : buffer_q;
        overflow_d = push_drop ? 1'b1 : (drain_done ? 1'b0 : overflow_q);
        eol_d      = eol_q;
        if (push_ok && rx_shift_q == EOL_CHAR)
            eol_d = 1'b1;
        else if (tx_pop && fifo_bus.count == CW'(1) && !push_ok)
            eol_d = 1'b0;
    end

    // ---------------- TX serializer ----------------
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_byte_d  = tx_byte_q;
        last_tx_d  = last_tx_q;
        tx_pop     = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                if (tx_en && !fifo_bus.empty) begin
                    tx_pop     = 1'b1;
                    tx_byte_d  = fifo_bus.pop_data;
                    tx_shift_d = fifo_bus.pop_data;
                    tx_cnt_d   = '0;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = TX_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_bit_d   = tx_bit_q + BIT_IDX_W'(1);
                    if (tx_bit_q == LAST_IDX) tx_state_d = TX_STOP;
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == BIT_LAST) begin
                    last_tx_d = tx_byte_q;
                    tx_cnt_d  = '0;
                    // Chain straight into the next start bit so back-to-back bytes have no gap.
                    if (tx_en && !fifo_bus.empty) begin
                        tx_pop     = 1'b1;
                        tx_byte_d  = fifo_bus.pop_data;
                        tx_shift_d = fifo_bus.pop_data;
                        tx_state_d = TX_START;
                    end else begin
                        tx_state_d = TX_IDLE;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_comb begin
        o_UART_TXD = LINE_IDLE;
        case (tx_state_q)
            TX_START: o_UART_TXD = START_BIT;
            TX_DATA:  o_UART_TXD = tx_shift_q[0];
            TX_STOP:  o_UART_TXD = STOP_BIT;
            default:  o_UART_TXD = LINE_IDLE;
        endcase
    end

    // ---------------- state registers ----------------
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            rxd_meta_q  <= LINE_IDLE;
            rxd_sync_q  <= LINE_IDLE;
            send_meta_q <= 1'b0;
            send_sync_q <= 1'b0;
            send_prev_q <= 1'b0;
            rx_state_q  <= RX_IDLE;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            tx_state_q  <= TX_IDLE;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_shift_q  <= '0;
            tx_byte_q   <= '0;
            last_tx_q   <= '0;
            drain_q     <= 1'b0;
            buffer_q    <= '0;
            eol_q       <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            rxd_meta_q  <= i_UART_RXD;
            rxd_sync_q  <= rxd_meta_q;
            send_meta_q <= i_send_data_to_host_computer;
            send_sync_q <= send_meta_q;
            send_prev_q <= send_sync_q;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_shift_q  <= tx_shift_d;
            tx_byte_q   <= tx_byte_d;
            last_tx_q   <= last_tx_d;
            drain_q     <= drain_d;
            buffer_q    <= buffer_d;
            eol_q       <= eol_d;
            overflow_q  <= overflow_d;
        end
    end

    assign o_buffer     = buffer_q;
    assign o_count_data = fifo_bus.count;
    assign o_last_tx    = last_tx_q;
    assign o_eol        = eol_q;
    assign o_overflow   = overflow_q;
    assign o_frame_err  = frame_err_q;

endmodule

// File: tb/tb_uart_line_buffer.sv
// Directed bench for uart_line_buffer at CLKS_PER_BIT=8, DEPTH=4, SHOW_BYTES=4.
module tb_uart_line_buffer;
    localparam int CPB   = 8;
    localparam int DEPTH = 4;
    localparam int SHOW  = 4;
    localparam int TX_LIMIT = 2000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rxd = 1'b1;
    logic send = 1'b0;
    logic echo = 1'b0;
    logic txd;
    logic [8*SHOW-1:0] buffer;
    logic [$clog2(DEPTH+1)-1:0] count;
    logic [7:0] last_tx;
    logic eol, overflow, frame_err;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int tx_low_cnt = 0;
    int fe_cnt = 0;

    uart_line_buffer #(
        .CLKS_PER_BIT (CPB),
        .DEPTH        (DEPTH),
        .SHOW_BYTES   (SHOW),
        .EOL_CHAR     (8'h0D)
    ) dut (
        .i_Clk                        (clk),
        .i_Rst_n                      (rst_n),
        .i_UART_RXD                   (rxd),
        .i_send_data_to_host_computer (send),
        .i_echo_mode                  (echo),
        .o_UART_TXD                   (txd),
        .o_buffer                     (buffer),
        .o_count_data                 (count),
        .o_last_tx                    (last_tx),
        .o_eol                        (eol),
        .o_overflow                   (overflow),
        .o_frame_err                  (frame_err)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (txd === 1'b0) tx_low_cnt++;
        if (frame_err === 1'b1) fe_cnt++;
    end

    task automatic do_reset();
        rst_n = 1'b0;
        rxd   = 1'b1;
        send  = 1'b0;
        echo  = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // ---------------- drivers ----------------
    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk);
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = stop;
        repeat (CPB) @(negedge clk);
        rxd = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Decodes one frame from TXD; returns at mid stop bit.
    task automatic recv_tx(output logic [7:0] b, output int fall_cyc, output bit ok);
        int t;
        logic start_lvl, stop_lvl;
        t = 0;
        ok = 1'b0;
        b = '0;
        fall_cyc = 0;
        while (txd !== 1'b0 && t < TX_LIMIT) begin
            @(negedge clk);
            t++;
        end
        if (t >= TX_LIMIT) return;
        fall_cyc = cyc;
        repeat (CPB / 2) @(negedge clk);
        start_lvl = txd;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            b[i] = txd;
        end
        repeat (CPB) @(negedge clk);
        stop_lvl = txd;
        ok = (start_lvl === 1'b0) && (stop_lvl === 1'b1);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        rxd = 1'b1; send = 1'b0; echo = 1'b0;
        repeat (2) @(negedge clk);
        tests++; if (txd !== 1'b1) begin fails++; $display("FAIL reset_txd: got %b want 1", txd); end
        tests++; if (buffer !== 32'h0) begin fails++; $display("FAIL reset_buffer: got %h want 00000000", buffer); end
        tests++; if (count !== 3'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", count); end
        tests++; if (last_tx !== 8'h00) begin fails++; $display("FAIL reset_last_tx: got %h want 00", last_tx); end
        tests++; if (eol !== 1'b0) begin fails++; $display("FAIL reset_eol: got %b want 0", eol); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_store();
        int low0;
        low0 = tx_low_cnt;
        send_byte(8'h41, 1'b1);
        send_byte(8'h42, 1'b1);
        repeat (20) @(negedge clk);
        tests++; if (count !== 3'd2) begin fails++; $display("FAIL store_count: got %0d want 2", count); end
        tests++; if (buffer !== 32'h00004142) begin fails++; $display("FAIL store_buffer: got %h want 00004142", buffer); end
        tests++; if (tx_low_cnt !== low0) begin fails++; $display("FAIL store_txd_idle: got %0d low cycles want 0", tx_low_cnt - low0); end
    endtask

    task automatic test_drain();
        logic [7:0] b0, b1;
        int f0, f1;
        bit ok0, ok1;
        send = 1'b1;
        recv_tx(b0, f0, ok0);
        recv_tx(b1, f1, ok1);
        tests++; if (!ok0 || b0 !== 8'h41) begin fails++; $display("FAIL drain_byte0: got %h ok=%0d want 41", b0, ok0); end
        tests++; if (!ok1 || b1 !== 8'h42) begin fails++; $display("FAIL drain_byte1: got %h ok=%0d want 42", b1, ok1); end
        tests++; if (f1 - f0 != 10 * CPB) begin fails++; $display("FAIL drain_back_to_back: got %0d cycles want %0d", f1 - f0, 10 * CPB); end
        repeat (12) @(negedge clk);
        tests++; if (last_tx !== 8'h42) begin fails++; $display("FAIL drain_last_tx: got %h want 42", last_tx); end
        tests++; if (count !== 3'd0) begin fails++; $display("FAIL drain_count: got %0d want 0", count); end
        send = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_overflow();
        logic [7:0] b;
        int f;
        bit ok;
        do_reset();
        for (int v = 1; v <= 5; v++) send_byte(8'(v), 1'b1);
        repeat (4) @(negedge clk);
        tests++; if (count !== 3'd4) begin fails++; $display("FAIL ovf_count: got %0d want 4", count); end
        tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        tests++; if (buffer !== 32'h01020304) begin fails++; $display("FAIL ovf_buffer: got %h want 01020304", buffer); end
        send = 1'b1;
        for (int i = 0; i < 4; i++) begin
            recv_tx(b, f, ok);
            tests++; if (!ok || b !== 8'(i + 1)) begin fails++; $display("FAIL ovf_drain_byte%0d: got %h ok=%0d want %h", i, b, ok, 8'(i + 1)); end
        end
        repeat (12) @(negedge clk);
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL ovf_clear_on_drain: got %b want 0", overflow); end
        tests++; if (count !== 3'd0) begin fails++; $display("FAIL ovf_drain_count: got %0d want 0", count); end
        send = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_eol();
        logic [7:0] b;
        int f;
        bit ok;
        send_byte(8'h0D, 1'b1);
        repeat (4) @(negedge clk);
        tests++; if (eol !== 1'b1) begin fails++; $display("FAIL eol_set: got %b want 1", eol); end
        tests++; if (count !== 3'd1) begin fails++; $display("FAIL eol_count: got %0d want 1", count); end
        send = 1'b1;
        recv_tx(b, f, ok);
        tests++; if (!ok || b !== 8'h0D) begin fails++; $display("FAIL eol_tx_byte: got %h ok=%0d want 0d", b, ok); end
        repeat (12) @(negedge clk);
        tests++; if (eol !== 1'b0) begin fails++; $display("FAIL eol_clear: got %b want 0", eol); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL eol_overflow: got %b want 0", overflow); end
        tests++; if (last_tx !== 8'h0D) begin fails++; $display("FAIL eol_last_tx: got %h want 0d", last_tx); end
        send = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_frame_err();
        int fe0;
        fe0 = fe_cnt;
        send_byte(8'hA5, 1'b0);
        repeat (4) @(negedge clk);
        tests++; if (fe_cnt - fe0 !== 1) begin fails++; $display("FAIL ferr_pulse: got %0d cycles want 1", fe_cnt - fe0); end
        tests++; if (count !== 3'd0) begin fails++; $display("FAIL ferr_count: got %0d want 0", count); end
        @(negedge clk);
        rxd = 1'b0;
        repeat (3) @(negedge clk);
        rxd = 1'b1;
        repeat (100) @(negedge clk);
        tests++; if (fe_cnt - fe0 !== 1) begin fails++; $display("FAIL glitch_ferr: got %0d cycles want 1", fe_cnt - fe0); end
        tests++; if (count !== 3'd0) begin fails++; $display("FAIL glitch_count: got %0d want 0", count); end
        send_byte(8'h3C, 1'b1);
        repeat (4) @(negedge clk);
        tests++; if (count !== 3'd1) begin fails++; $display("FAIL post_err_count: got %0d want 1", count); end
        tests++; if (buffer !== 32'h03040D3C) begin fails++; $display("FAIL post_err_buffer: got %h want 03040d3c", buffer); end
    endtask

    task automatic test_echo_reset();
        logic [7:0] b;
        int f, low0;
        bit ok;
        do_reset();
        echo = 1'b1;
        low0 = tx_low_cnt;
        send_byte(8'h55, 1'b1);
        repeat (16) @(negedge clk);
        tests++; if (tx_low_cnt == low0) begin fails++; $display("FAIL echo_started: got 0 low cycles want >0"); end
        #2 rst_n = 1'b0;
        #1;
        tests++; if (txd !== 1'b1) begin fails++; $display("FAIL midtx_reset_txd: got %b want 1", txd); end
        tests++; if (buffer !== 32'h0) begin fails++; $display("FAIL midtx_reset_buffer: got %h want 00000000", buffer); end
        tests++; if (count !== 3'd0) begin fails++; $display("FAIL midtx_reset_count: got %0d want 0", count); end
        tests++; if (last_tx !== 8'h00) begin fails++; $display("FAIL midtx_reset_last_tx: got %h want 00", last_tx); end
        tests++; if (eol !== 1'b0 || overflow !== 1'b0 || frame_err !== 1'b0) begin
            fails++; $display("FAIL midtx_reset_flags: got eol=%b ovf=%b ferr=%b want 0 0 0", eol, overflow, frame_err);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        fork
            send_byte(8'hA7, 1'b1);
            recv_tx(b, f, ok);
        join
        tests++; if (!ok || b !== 8'hA7) begin fails++; $display("FAIL echo_byte: got %h ok=%0d want a7", b, ok); end
        repeat (12) @(negedge clk);
        tests++; if (last_tx !== 8'hA7) begin fails++; $display("FAIL echo_last_tx: got %h want a7", last_tx); end
        tests++; if (buffer !== 32'h000000A7) begin fails++; $display("FAIL echo_buffer: got %h want 000000a7", buffer); end
        tests++; if (count !== 3'd0) begin fails++; $display("FAIL echo_count: got %0d want 0", count); end
        echo = 1'b0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_store();
        test_drain();
        test_overflow();
        test_eol();
        test_frame_err();
        test_echo_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_line_buffer.md
UART_LINE_BUFFER -- requirements
Module: uart_line_buffer

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clock cycles per UART bit (115200 baud at 50 MHz); minimum 4.
REQ-002 SHALL have parameter DEPTH, default 32, FIFO byte capacity; power of two, 2..256.
REQ-003 SHALL have parameter SHOW_BYTES, default 4, number of most recent received bytes exposed on o_buffer.
REQ-004 SHALL have parameter EOL_CHAR, default 8'h0D, end-of-line byte value.
REQ-005 SHALL have port i_Clk  in  1  single system clock, all logic on rising edge.
REQ-006 SHALL have port i_Rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port i_UART_RXD  in  1  asynchronous serial input, 8N1, idle high.
REQ-008 SHALL have port i_send_data_to_host_computer  in  1  asynchronous level; a rising edge requests a drain.
REQ-009 SHALL have port i_echo_mode  in  1  1 = transmit every accepted byte immediately; 0 = store until a drain is requested.
REQ-010 SHALL have port o_UART_TXD  out  1  serial output, 8N1, idle high.
REQ-011 SHALL have port o_buffer  out  8*SHOW_BYTES  last accepted bytes; newest byte in bits [7:0].
REQ-012 SHALL have port o_count_data  out  $clog2(DEPTH+1)  current FIFO occupancy.
REQ-013 SHALL have port o_last_tx  out  8  last byte fully transmitted.
REQ-014 SHALL have port o_eol  out  1  EOL_CHAR currently held in FIFO.
REQ-015 SHALL have port o_overflow  out  1  sticky flag: a byte was dropped because the FIFO was full.
REQ-016 SHALL have port o_frame_err  out  1  one-cycle pulse on stop-bit error.

Function
REQ-017 i_UART_RXD and i_send_data_to_host_computer SHALL each pass through a 2-FF synchronizer before use.
REQ-018 RX FSM SHALL use states IDLE, START, DATA, STOP: IDLE->START on synchronized low; START re-samples at CLKS_PER_BIT/2 and returns to IDLE if the line is high (glitch); otherwise it goes to DATA.
REQ-019 DATA SHALL sample 8 bits LSB-first at intervals of CLKS_PER_BIT; STOP then samples once more: high -> accept byte; low -> discard byte, pulse o_frame_err, return to IDLE.
REQ-020 An accepted byte SHALL be written to the FIFO one cycle after the stop-bit sample; if the FIFO is full in that cycle the byte SHALL be dropped, o_overflow set and o_buffer left unchanged.
REQ-021 The full condition SHALL be evaluated before any same-cycle pop; a pop in the same cycle does not rescue the write.
REQ-022 On every written byte, o_buffer SHALL shift left by 8 and load the byte into [7:0].
REQ-023 A simultaneous push and pop SHALL leave o_count_data unchanged.
REQ-024 A rising edge on the synchronized send input SHALL set a drain flag; the drain continues until the FIFO is empty, including bytes that arrive during the drain.
REQ-025 A new send edge during an active drain SHALL be ignored.
REQ-026 When i_echo_mode=1, the TX path SHALL pop whenever the FIFO is not empty, with no drain request needed.
REQ-027 TX FSM SHALL use states IDLE, START, DATA, STOP, each bit lasting CLKS_PER_BIT cycles.
REQ-028 TX SHALL pop in IDLE when enabled and not empty, and drive the start bit on the following cycle.
REQ-029 o_last_tx SHALL update at the end of STOP; back-to-back bytes SHALL have no idle gap.
REQ-030 o_eol SHALL set when EOL_CHAR is written to the FIFO and clear when the FIFO becomes empty through a pop.
REQ-031 o_overflow SHALL clear only on reset or on completion of a drain.
REQ-032 The drain flag SHALL clear when the FIFO is empty and TX has returned to IDLE.
REQ-033 Changing i_echo_mode mid-byte SHALL NOT truncate the byte currently being transmitted.

Reset
REQ-034 Reset assertion SHALL asynchronously return both FSMs to IDLE and empty the FIFO.
REQ-035 During reset: o_UART_TXD=1, o_buffer=0, o_count_data=0, o_last_tx=0, o_eol=0, o_overflow=0, o_frame_err=0, drain flag=0.
REQ-036 Reset asserted mid-frame SHALL abort the frame; the next start bit after release is received normally.

Structure
REQ-037 A shared package uart_pkg SHALL hold the RX/TX state typedefs, the 8N1 frame constants and the EOL default.
REQ-038 The FIFO SHALL be a single sub-module, ulb_fifo (parameter DEPTH, ports push/pop/full/empty/count).
REQ-039 The RX and TX FSMs SHALL be implemented inline in uart_line_buffer.

Verification (CLKS_PER_BIT=8, DEPTH=4, SHOW_BYTES=4)
REQ-040 Send 8'h41, 8'h42 with echo=0 -> o_count_data=2, o_buffer=32'h00004142, TXD stays high.
REQ-041 Send 8'h41, 8'h42, then raise the send input -> TXD emits 41 then 42 back-to-back; o_last_tx=8'h42; count=0.
REQ-042 Send 5 bytes 01..05 with echo=0 -> count=4, o_overflow=1, o_buffer=32'h01020304.
REQ-043 Send 8'h0D -> o_eol=1; drain -> o_eol=0 and o_overflow=0 after completion.
REQ-044 Send a frame whose stop bit is 0 -> one-cycle o_frame_err, count unchanged; a 3-cycle low glitch is ignored.
REQ-045 echo=1, send 8'h55, assert reset mid-TX-frame -> TXD=1 at once and all outputs zero; a frame after release echoes correctly.
